ppu_vram_port: RTL

- Initiator side of the PPU memory bus; drives the 14-bit addr / 8-bit data / rw / q interface of the PPU memory wrapper.
- Implements the CPU-visible VRAM access path:
  - PPUADDR ($2006) two-write address latch with toggle.
  - PPUDATA ($2007) read/write with delayed read buffer and auto-increment by 1 or 32.
  - Internal 32-byte palette RAM.
- Arbitrates between CPU-initiated accesses and the render fetch pipeline; rendering always has priority.

---
 rtl/ppu_vram_port.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_port.sv
// PPU-side VRAM port: $2006/$2007 access path, palette RAM, and render/CPU bus arbitration.
// The render fetch pipeline always owns the bus while rend_req is high.
module ppu_vram_port #(
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(14'h3F00)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cpu_din,
  input  logic              wr_addr_stb,
  input  logic              wr_data_stb,
  input  logic              rd_data_stb,
  input  logic              status_rd_stb,
  input  logic              inc32,
  output logic [7:0]        cpu_dout,
  output logic              cpu_dout_vld,
  output logic              busy,
  output logic              ovf,
  input  logic              rend_req,
  input  logic [ADDR_W-1:0] rend_addr,
  output logic [7:0]        rend_q,
  input  logic [4:0]        pal_idx,
  output logic [5:0]        pal_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_rw,
  input  logic [7:0]        mem_q
);

  localparam int HI_W = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] NT_MASK = ADDR_W'(14'h2FFF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_CAP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] v_r;
  logic [ADDR_W-1:0] v_op_r;
  logic [HI_W-1:0]   t_hi_r;
  logic              w_r;
  logic [7:0]        wdat_r;
  logic [7:0]        rd_buf_r;
  logic [5:0]        pal_r [32];
  logic [7:0]        cpu_dout_r;
  logic              cpu_dout_vld_r;
  logic              ovf_r;

  logic [ADDR_W-1:0] inc_s;
  logic              cpu_stb_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_rw_s;

  // Universal background colour entries 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C.
  function automatic logic [4:0] pal_alias(input logic [4:0] idx);
    if (idx[4] && (idx[1:0] == 2'b00)) begin
      pal_alias = {1'b0, idx[3:0]};
    end else begin
      pal_alias = idx;
    end
  endfunction

  function automatic logic is_pal(input logic [ADDR_W-1:0] a);
    is_pal = (a >= PAL_BASE);
  endfunction

  assign inc_s     = inc32 ? ADDR_W'(32) : ADDR_W'(1);
  assign cpu_stb_s = wr_data_stb | rd_data_stb;

  // Bus address/direction mux: render fetch overrides whatever the CPU path wants.
  always_comb begin
    mem_addr_s = v_r;
    mem_rw_s   = 1'b0;
    if (rend_req) begin
      mem_addr_s = rend_addr;
    end else begin
      case (state_r)
        WR: begin
          if (!is_pal(v_op_r)) begin
            mem_addr_s = v_op_r;
            mem_rw_s   = 1'b1;
          end else begin
            mem_addr_s = v_r;
          end
        end
        RD_ADDR: mem_addr_s = is_pal(v_op_r) ? (v_op_r & NT_MASK) : v_op_r;
        default: mem_addr_s = v_r;
      endcase
    end
  end

  // Access FSM, address latch, read buffer and palette storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      v_r            <= '0;
      v_op_r         <= '0;
      t_hi_r         <= '0;
      w_r            <= 1'b0;
      wdat_r         <= 8'h00;
      rd_buf_r       <= 8'h00;
      cpu_dout_r     <= 8'h00;
      cpu_dout_vld_r <= 1'b0;
      ovf_r          <= 1'b0;
      for (int i = 0; i < 32; i++) pal_r[i] <= 6'h00;
    end else begin
      cpu_dout_vld_r <= 1'b0;
      ovf_r          <= cpu_stb_s && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (wr_data_stb) begin
            v_op_r  <= v_r;
            v_r     <= v_r + inc_s;
            wdat_r  <= cpu_din;
            state_r <= WR;
          end else if (rd_data_stb) begin
            v_op_r         <= v_r;
            v_r            <= v_r + inc_s;
            cpu_dout_r     <= is_pal(v_r) ? {2'b00, pal_r[pal_alias(v_r[4:0])]} : rd_buf_r;
            cpu_dout_vld_r <= 1'b1;
            state_r        <= RD_ADDR;
          end else begin
            state_r <= IDLE;
          end
        end
        WR: begin
          if (!rend_req) begin
            if (is_pal(v_op_r)) pal_r[pal_alias(v_op_r[4:0])] <= wdat_r[5:0];
            state_r <= IDLE;
          end
        end
        RD_ADDR: begin
          if (!rend_req) state_r <= RD_CAP;
        end
        // mem_q still reflects the CPU address from RD_ADDR, so this step never stalls.
        RD_CAP: begin
          rd_buf_r <= mem_q;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      // A completing $2006 pair takes precedence over the $2007 increment.
      if (status_rd_stb) begin
        w_r <= 1'b0;
      end else if (wr_addr_stb) begin
        if (!w_r) begin
          t_hi_r <= cpu_din[HI_W-1:0];
          w_r    <= 1'b1;
        end else begin
          v_r <= {t_hi_r, cpu_din};
          w_r <= 1'b0;
        end
      end
    end
  end

  assign cpu_dout     = cpu_dout_r;
  assign cpu_dout_vld = cpu_dout_vld_r;
  assign ovf          = ovf_r;
  assign busy         = (state_r != IDLE);
  assign mem_addr     = mem_addr_s;
  assign mem_rw       = mem_rw_s;
  assign mem_data     = wdat_r;
  assign rend_q       = mem_q;
  assign pal_q        = pal_r[pal_alias(pal_idx)];

endmodule
